udp_vlg_rx: RTL

- Downstream neighbour of the IPv4 receive stage; consumes the IPv4 payload byte stream with val/sof/eof framing.
- Parses the 8-byte UDP header and filters on destination port.
- Strips the header and any trailing padding, then forwards the UDP payload with per-datagram metadata to the application/socket layer.
- Checksum is not verified; the checksum bytes are consumed and discarded.

---
 rtl/udp_vlg_rx.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/udp_vlg_rx.sv
// UDP receive stage: parses the 8-byte header of an IPv4 payload, filters on
// destination port and forwards the payload with per-datagram metadata.
//
// state | meaning
// IDLE  | waiting for in_sof
// HDR   | consuming header bytes 0-7
// PLD   | forwarding payload, cnt_q bytes left
// DROP  | discarding bytes until in_eof
module udp_vlg_rx #(
   parameter logic [7:0] PROTO_UDP   = 8'd17,
   parameter bit         PORT_FILTER = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cfg_port,
   input  logic [7:0]  in_dat,
   input  logic        in_val,
   input  logic        in_sof,
   input  logic        in_eof,
   input  logic [7:0]  in_proto,
   input  logic [31:0] in_src_ip,
   output logic [7:0]  out_dat,
   output logic        out_val,
   output logic        out_sof,
   output logic        out_eof,
   output logic        out_err,
   output logic [15:0] out_src_port,
   output logic [15:0] out_dst_port,
   output logic [15:0] out_len,
   output logic [31:0] out_src_ip,
   output logic        stat_drop
);

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_PLD, S_DROP} state_t;

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d, cnt_q, cnt_d;
   logic        first_q, first_d;
   logic [7:0]  out_dat_q, out_dat_d;
   logic        out_val_q, out_val_d, out_sof_q, out_sof_d;
   logic        out_eof_q, out_eof_d, out_err_q, out_err_d;
   logic [15:0] out_src_port_q, out_src_port_d, out_dst_port_q, out_dst_port_d;
   logic [15:0] out_len_q, out_len_d;
   logic [31:0] out_src_ip_q, out_src_ip_d;
   logic        stat_drop_q, stat_drop_d;

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      src_d          = src_q;
      dst_d          = dst_q;
      len_d          = len_q;
      cnt_d          = cnt_q;
      first_d        = first_q;
      out_dat_d      = out_dat_q;
      out_val_d      = 1'b0;
      out_sof_d      = 1'b0;
      out_eof_d      = 1'b0;
      out_err_d      = 1'b0;
      out_src_port_d = out_src_port_q;
      out_dst_port_d = out_dst_port_q;
      out_len_d      = out_len_q;
      out_src_ip_d   = out_src_ip_q;
      stat_drop_d    = 1'b0;

      if (in_val) begin
         if (in_sof) begin
            // A sof outside IDLE aborts whatever was in flight.
            if (state_q == S_PLD) out_err_d = 1'b1;
            if (state_q == S_HDR || state_q == S_PLD) stat_drop_d = 1'b1;
            idx_d = 3'd1;
            if (in_proto == PROTO_UDP) begin
               src_d[15:8] = in_dat;
               if (in_eof) begin
                  stat_drop_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  state_d = S_HDR;
               end
            end else begin
               state_d = in_eof ? S_IDLE : S_DROP;
            end
         end else begin
            case (state_q)
               S_HDR: begin
                  idx_d = idx_q + 3'd1;
                  case (idx_q)
                     3'd1:    src_d[7:0]  = in_dat;
                     3'd2:    dst_d[15:8] = in_dat;
                     3'd3:    dst_d[7:0]  = in_dat;
                     3'd4:    len_d[15:8] = in_dat;
                     3'd5:    len_d[7:0]  = in_dat;
                     default: ;
                  endcase
                  if (idx_q == 3'd7) begin
                     out_src_port_d = src_q;
                     out_dst_port_d = dst_q;
                     out_len_d      = (len_q < 16'd8) ? 16'd0 : len_q - 16'd8;
                     out_src_ip_d   = in_src_ip;
                     if (len_q < 16'd8 || (PORT_FILTER && dst_q != cfg_port)) begin
                        stat_drop_d = 1'b1;
                        state_d     = in_eof ? S_IDLE : S_DROP;
                     end else if (len_q == 16'd8) begin
                        state_d = in_eof ? S_IDLE : S_DROP;
                     end else if (in_eof) begin
                        stat_drop_d = 1'b1;
                        state_d     = S_IDLE;
                     end else begin
                        cnt_d   = len_q - 16'd8;
                        first_d = 1'b1;
                        state_d = S_PLD;
                     end
                  end else if (in_eof) begin
                     stat_drop_d = 1'b1;
                     state_d     = S_IDLE;
                  end
               end
               S_PLD: begin
                  out_val_d = 1'b1;
                  out_dat_d = in_dat;
                  out_sof_d = first_q;
                  first_d   = 1'b0;
                  cnt_d     = cnt_q - 16'd1;
                  if (cnt_q == 16'd1) begin
                     out_eof_d = 1'b1;
                     state_d   = in_eof ? S_IDLE : S_DROP;
                  end else if (in_eof) begin
                     out_eof_d = 1'b1;
                     out_err_d = 1'b1;
                     state_d   = S_IDLE;
                  end
               end
               S_DROP: if (in_eof) state_d = S_IDLE;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         idx_q          <= 3'd0;
         src_q          <= 16'd0;
         dst_q          <= 16'd0;
         len_q          <= 16'd0;
         cnt_q          <= 16'd0;
         first_q        <= 1'b0;
         out_dat_q      <= 8'd0;
         out_val_q      <= 1'b0;
         out_sof_q      <= 1'b0;
         out_eof_q      <= 1'b0;
         out_err_q      <= 1'b0;
         out_src_port_q <= 16'd0;
         out_dst_port_q <= 16'd0;
         out_len_q      <= 16'd0;
         out_src_ip_q   <= 32'd0;
         stat_drop_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         src_q          <= src_d;
         dst_q          <= dst_d;
         len_q          <= len_d;
         cnt_q          <= cnt_d;
         first_q        <= first_d;
         out_dat_q      <= out_dat_d;
         out_val_q      <= out_val_d;
         out_sof_q      <= out_sof_d;
         out_eof_q      <= out_eof_d;
         out_err_q      <= out_err_d;
         out_src_port_q <= out_src_port_d;
         out_dst_port_q <= out_dst_port_d;
         out_len_q      <= out_len_d;
         out_src_ip_q   <= out_src_ip_d;
         stat_drop_q    <= stat_drop_d;
      end
   end

   assign out_dat      = out_dat_q;
   assign out_val      = out_val_q;
   assign out_sof      = out_sof_q;
   assign out_eof      = out_eof_q;
   assign out_err      = out_err_q;
   assign out_src_port = out_src_port_q;
   assign out_dst_port = out_dst_port_q;
   assign out_len      = out_len_q;
   assign out_src_ip   = out_src_ip_q;
   assign stat_drop    = stat_drop_q;

endmodule
